material_loader: RTL and testbench

MATERIAL_LOADER -- requirements
Module: material_loader

---
 rtl/material_loader.sv | 74 +++++++
 tb/tb_material_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/material_loader.sv
// material_loader: assembles 10-word host payloads into 289-bit L2 material records
// and sequences the L2-to-L1 flush with a fixed hold-off.
module material_loader #(
   parameter int FLUSH_CYCLES = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic         l2_write_enable,
   output logic [2:0]   l2_write_id,
   output logic [288:0] l2_write_material,
   output logic         l2_flush_to_l1,
   output logic         busy,
   output logic [7:0]   pending_mask
);
   localparam int WW = $clog2(FLUSH_CYCLES) > 5 ? $clog2(FLUSH_CYCLES) : 5;
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, FLUSH, WAIT} state_t;
   state_t          state_q;
   logic [3:0]      cnt_q;
   logic [WW-1:0]   wait_q;
   logic [2:0]      id_q;
   assign s_ready         = state_q == IDLE || state_q == LOAD;
   assign busy            = state_q != IDLE;
   assign l2_write_enable = state_q == WRITE;
   assign l2_flush_to_l1  = state_q == FLUSH;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         wait_q            <= '0;
         id_q              <= '0;
         l2_write_id       <= '0;
         l2_write_material <= '0;
         pending_mask      <= '0;
      end else begin
         case (state_q)
            IDLE: if (s_valid) begin
               if (s_data[31]) begin
                  pending_mask <= '0;
                  state_q      <= FLUSH;
               end else begin
                  id_q    <= s_data[2:0];
                  cnt_q   <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: if (s_valid) begin
               // the tenth word contributes only its LSB to the record's top bit
               if (cnt_q == 4'd9) begin
                  l2_write_material[288] <= s_data[0];
                  l2_write_id            <= id_q;
                  pending_mask[id_q]     <= 1'b1;
                  state_q                <= WRITE;
               end else begin
                  l2_write_material[{cnt_q, 5'd0} +: 32] <= s_data;
                  cnt_q                                  <= cnt_q + 4'd1;
               end
            end
            WRITE: state_q <= IDLE;
            FLUSH: begin
               wait_q  <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               wait_q <= wait_q + 1'b1;
               if (wait_q == WW'(FLUSH_CYCLES - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_material_loader.sv
// tb_material_loader: directed vectors with hand-computed records, latencies and strobe counts.
module tb_material_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         s_valid = 1'b0;
   logic [31:0]  s_data = 32'h0;
   logic         s_ready, l2_write_enable, l2_flush_to_l1, busy;
   logic [2:0]   l2_write_id;
   logic [288:0] l2_write_material;
   logic [7:0]   pending_mask;
   int checks = 0, failures = 0, cyc = 0, we_cnt = 0, fl_cnt = 0, bad = 0;
   bit hold = 1'b0;
   material_loader #(.FLUSH_CYCLES(17)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .l2_write_enable(l2_write_enable), .l2_write_id(l2_write_id),
      .l2_write_material(l2_write_material), .l2_flush_to_l1(l2_flush_to_l1),
      .busy(busy), .pending_mask(pending_mask)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // strobe monitor: counts pulses and flags writes overlapping a flush or its hold-off
   always @(negedge clk) begin
      if (l2_write_enable) we_cnt++;
      if (l2_flush_to_l1) fl_cnt++;
      if (l2_write_enable && (l2_flush_to_l1 || hold)) bad++;
      hold = l2_flush_to_l1 || (hold && busy);
   end
   task automatic chk(input string tag, input logic [288:0] got, input logic [288:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic xfer(input logic [31:0] w);
      s_data  = w;
      s_valid = 1'b1;
      for (int i = 0; i < 100 && !s_ready; i++) @(negedge clk);
      if (!s_ready) chk("xfer_timeout", 1, 0);
      @(negedge clk);
      s_valid = 1'b0;
   endtask
   task automatic load(input logic [2:0] id, input logic [31:0] w [10], input int stall, output int lat);
      int c0;
      xfer({29'd0, id});
      c0 = cyc;
      for (int k = 0; k < 10; k++) begin
         xfer(w[k]);
         if (k == stall) begin
            s_data = 32'hdead_beef;
            repeat (3) @(negedge clk);
         end
      end
      lat = cyc - c0;
   endtask
   task automatic wait_ready(output int n, output int bz);
      n  = 1;
      bz = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_ready) return;
         n++;
         if (!busy) bz++;
      end
   endtask
   function automatic logic [288:0] pack(input logic [31:0] w [10]);
      logic [288:0] m = '0;
      for (int k = 0; k < 9; k++) m[32*k +: 32] = w[k];
      m[288] = w[9][0];
      return m;
   endfunction
   initial begin
      logic [31:0] w [10];
      logic [31:0] a [10];
      logic [31:0] b [10];
      logic [288:0] rec1;
      int lat, n, bz, w0, f0;
      rec1 = {1'b1, 192'd0, {3{32'h0100_0000}}};
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_we", l2_write_enable, 0);
      chk("rst_flush", l2_flush_to_l1, 0);
      chk("rst_pending", pending_mask, 0);
      chk("rst_id", l2_write_id, 0);
      chk("rst_material", l2_write_material, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", s_ready, 1);
      // basic load, s_valid held high
      w = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
      w0 = we_cnt;
      load(3'd5, w, -1, lat);
      chk("t1_we", l2_write_enable, 1);
      chk("t1_id", l2_write_id, 5);
      chk("t1_pending", pending_mask, 8'h20);
      chk("t1_material", l2_write_material, rec1);
      chk("t1_latency", lat, 10);
      chk("t1_rdy_in_write", s_ready, 0);
      @(negedge clk);
      chk("t1_we_off", l2_write_enable, 0);
      chk("t1_idle", busy, 0);
      repeat (2) @(negedge clk);
      chk("t1_we_count", we_cnt - w0, 1);
      // same load with a 3-cycle stall
      w0 = we_cnt;
      load(3'd5, w, 4, lat);
      chk("t2_we", l2_write_enable, 1);
      chk("t2_latency", lat, 13);
      chk("t2_material", l2_write_material, rec1);
      chk("t2_pending", pending_mask, 8'h20);
      repeat (3) @(negedge clk);
      chk("t2_we_count", we_cnt - w0, 1);
      // commit with a header offered during the hold-off
      w0 = we_cnt;
      f0 = fl_cnt;
      xfer(32'h8000_0000);
      chk("t3_flush", l2_flush_to_l1, 1);
      chk("t3_pending", pending_mask, 0);
      chk("t3_rdy", s_ready, 0);
      chk("t3_busy", busy, 1);
      chk("t3_we", l2_write_enable, 0);
      s_data  = 32'h0000_0004;
      s_valid = 1'b1;
      wait_ready(n, bz);
      s_valid = 1'b0;
      chk("t3_rdy_low_cycles", n, 18);
      chk("t3_busy_gaps", bz, 0);
      chk("t3_idle", busy, 0);
      @(negedge clk);
      chk("t3_wait_word_dropped", busy, 0);
      repeat (2) @(negedge clk);
      chk("t3_flush_count", fl_cnt - f0, 1);
      chk("t3_we_count", we_cnt - w0, 0);
      // reset in the middle of a load
      w0 = we_cnt;
      xfer(32'h0000_0002);
      for (int k = 0; k < 6; k++) xfer(32'hffff_ffff);
      rst = 1'b0;
      @(negedge clk);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_material", l2_write_material, 0);
      chk("t4_rst_we", l2_write_enable, 0);
      rst = 1'b1;
      for (int k = 0; k < 9; k++) w[k] = 32'h00a0_0000 + 32'(k);
      w[9] = 32'h0000_0003;
      load(3'd2, w, -1, lat);
      chk("t4_id", l2_write_id, 2);
      chk("t4_pending", pending_mask, 8'h04);
      chk("t4_material", l2_write_material, pack(w));
      repeat (3) @(negedge clk);
      chk("t4_we_count", we_cnt - w0, 1);
      // two loads to the same slot, then commit
      xfer(32'h8000_0000);
      wait_ready(n, bz);
      chk("t5_pre_pending", pending_mask, 0);
      for (int k = 0; k < 10; k++) begin
         a[k] = 32'h3a00_0000 + 32'(k);
         b[k] = 32'h3b00_0000 + 32'(7 * k);
      end
      a[9] = 32'h0000_0000;
      b[9] = 32'h0000_0001;
      w0 = we_cnt;
      load(3'd3, a, -1, lat);
      chk("t5_pending_a", pending_mask, 8'h08);
      chk("t5_material_a", l2_write_material, pack(a));
      @(negedge clk);
      load(3'd3, b, -1, lat);
      chk("t5_id_b", l2_write_id, 3);
      chk("t5_pending_b", pending_mask, 8'h08);
      @(negedge clk);
      chk("t5_material_held", l2_write_material, pack(b));
      xfer(32'h8000_0000);
      chk("t5_flush", l2_flush_to_l1, 1);
      chk("t5_pending_flush", pending_mask, 0);
      wait_ready(n, bz);
      repeat (2) @(negedge clk);
      chk("t5_we_count", we_cnt - w0, 2);
      chk("t5_material_after_flush", l2_write_material, pack(b));
      // commit straight out of reset
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      f0 = fl_cnt;
      xfer(32'h8000_0000);
      chk("t6_flush", l2_flush_to_l1, 1);
      wait_ready(n, bz);
      chk("t6_rdy_low_cycles", n, 18);
      chk("t6_rdy", s_ready, 1);
      repeat (2) @(negedge clk);
      chk("t6_flush_count", fl_cnt - f0, 1);
      chk("no_overlap_or_hold_write", bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
